nco_wave_gen: RTL and testbench

NCO_WAVE_GEN -- requirements
Module: nco_wave_gen

---
 rtl/nco_wave_gen.sv | 165 ++++++++++++++++
 tb/tb_nco_wave_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/nco_wave_gen.sv
// Quadrature NCO: phase accumulator driving sine/square/saw/triangle on Y (phase) and X (phase+90 deg).
// Three-clock latency from input capture to X/Y/valid_o; no backpressure, the pipeline advances every cycle.
module nco_wave_gen #(
    parameter int PHASE_W = 24,
    parameter int OUT_W   = 10,
    parameter int LUT_AW  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      sync,
    input  logic                      load,
    input  logic [PHASE_W-1:0]        fcw,
    input  logic [PHASE_W-1:0]        poff,
    input  logic [1:0]                mode,
    output logic signed [OUT_W-1:0]   X,
    output logic signed [OUT_W-1:0]   Y,
    output logic                      valid_o
);

    localparam int LUT_N = 1 << LUT_AW;
    localparam int PW2   = LUT_AW + 2;
    localparam logic signed [OUT_W-1:0] POS_A = OUT_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [OUT_W-1:0] NEG_A = -POS_A;
    localparam logic [PHASE_W-1:0]      QTR   = {2'b01, {(PHASE_W - 2){1'b0}}};

    // Taylor series is exact to well below one LSB on [0, pi/2]; evaluated at elaboration only.
    function automatic real f_sin(input real x);
        real s;
        real term;
        s    = x;
        term = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            s    = s + term;
        end
        return s;
    endfunction

    function automatic logic [OUT_W-1:0] f_lut_entry(input int k);
        real ang;
        real amp;
        ang = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(LUT_N);
        amp = real'((1 << (OUT_W - 1)) - 1);
        return OUT_W'($rtoi(amp * f_sin(ang) + 0.5));
    endfunction

    function automatic logic signed [OUT_W-1:0] f_wave(
        input logic [1:0]       md,
        input logic             msb,
        input logic [OUT_W-1:0] u,
        input logic [OUT_W-1:0] mag
    );
        logic [OUT_W-1:0]     fold;
        logic signed [OUT_W:0] tri_w;
        fold   = u[OUT_W-1] ? ~u : u;
        tri_w  = $signed({fold, 1'b0}) - $signed({1'b0, POS_A});
        f_wave = '0;
        case (md)
            2'b00:   f_wave = msb ? -$signed(mag) : $signed(mag);
            2'b01:   f_wave = msb ? NEG_A : POS_A;
            2'b10:   f_wave = {~u[OUT_W-1], u[OUT_W-2:0]};
            default: f_wave = OUT_W'(tri_w);
        endcase
    endfunction

    logic [OUT_W-1:0] w_lut [LUT_N];

    generate
        for (genvar k = 0; k < LUT_N; k++) begin : g_lut
            assign w_lut[k] = f_lut_entry(k);
        end
    endgenerate

    logic [PHASE_W-1:0]      r_acc;
    logic [PHASE_W-1:0]      r_fcw;
    logic [PHASE_W-1:0]      r_p1;
    logic [1:0]              r_mode1;
    logic                    r_vld1;
    logic signed [OUT_W-1:0] r_x2;
    logic signed [OUT_W-1:0] r_y2;
    logic                    r_vld2;

    // Sync outranks increment; the increment always uses the fcw_reg value from before a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_fcw <= '0;
        end else begin
            if (sync) begin
                r_acc <= '0;
            end else if (en) begin
                r_acc <= r_acc + r_fcw;
            end
            if (load) begin
                r_fcw <= fcw;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1    <= '0;
            r_mode1 <= '0;
            r_vld1  <= 1'b0;
        end else begin
            r_p1    <= r_acc + poff;
            r_mode1 <= mode;
            r_vld1  <= en;
        end
    end

    logic [PHASE_W-1:0]      w_ph_y;
    logic [PHASE_W-1:0]      w_ph_x;
    logic [PW2-1:0]          w_py;
    logic [PW2-1:0]          w_px;
    logic [OUT_W-1:0]        w_uy;
    logic [OUT_W-1:0]        w_ux;
    logic [LUT_AW-1:0]       w_iy;
    logic [LUT_AW-1:0]       w_ix;
    logic signed [OUT_W-1:0] w_wave_y;
    logic signed [OUT_W-1:0] w_wave_x;
    logic                    w_unused_bits;

    assign w_ph_y = r_p1;
    assign w_ph_x = r_p1 + QTR;
    assign w_py   = w_ph_y[PHASE_W-1 -: PW2];
    assign w_px   = w_ph_x[PHASE_W-1 -: PW2];
    assign w_uy   = w_ph_y[PHASE_W-1 -: OUT_W];
    assign w_ux   = w_ph_x[PHASE_W-1 -: OUT_W];

    // Odd quadrants read the quarter-wave table mirrored.
    assign w_iy = w_py[LUT_AW] ? ~w_py[LUT_AW-1:0] : w_py[LUT_AW-1:0];
    assign w_ix = w_px[LUT_AW] ? ~w_px[LUT_AW-1:0] : w_px[LUT_AW-1:0];

    assign w_wave_y = f_wave(r_mode1, w_py[PW2-1], w_uy, w_lut[w_iy]);
    assign w_wave_x = f_wave(r_mode1, w_px[PW2-1], w_ux, w_lut[w_ix]);

    assign w_unused_bits = ^{w_ph_y, w_ph_x};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x2   <= '0;
            r_y2   <= '0;
            r_vld2 <= 1'b0;
        end else begin
            r_x2   <= w_wave_x;
            r_y2   <= w_wave_y;
            r_vld2 <= r_vld1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            X       <= '0;
            Y       <= '0;
            valid_o <= 1'b0;
        end else begin
            X       <= r_x2;
            Y       <= r_y2;
            valid_o <= r_vld2;
        end
    end

endmodule

// File: tb/tb_nco_wave_gen.sv
// Scoreboard bench for nco_wave_gen: a phase/waveform reference model predicts every en-qualified sample,
// an independent monitor pops and compares whenever valid_o is high.
module tb_nco_wave_gen;

    localparam int PW    = 24;
    localparam int OW    = 10;
    localparam int LA    = 8;
    localparam int A     = 511;
    localparam int NOLIT = 99999;

    typedef struct {
        int x;
        int y;
        int lx;
        int ly;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  en;
    logic                  sync;
    logic                  load;
    logic [PW-1:0]         fcw;
    logic [PW-1:0]         poff;
    logic [1:0]            mode;
    logic signed [OW-1:0]  X;
    logic signed [OW-1:0]  Y;
    logic                  valid_o;

    int        checks = 0;
    int        errors = 0;
    int        pushed = 0;
    int        popped = 0;
    bit [23:0] m_acc;
    bit [23:0] m_fcw;
    exp_t      sb_q[$];
    int        lut[256];
    int        ysin[4] = '{2, 511, -2, -511};
    int        xsin[4] = '{511, -2, -511, 2};
    int        ysq[4]  = '{511, 511, -511, -511};
    int        xsq[4]  = '{511, -511, -511, 511};

    always #5 clk = ~clk;

    nco_wave_gen #(.PHASE_W(PW), .OUT_W(OW), .LUT_AW(LA)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .sync    (sync),
        .load    (load),
        .fcw     (fcw),
        .poff    (poff),
        .mode    (mode),
        .X       (X),
        .Y       (Y),
        .valid_o (valid_o)
    );

    // Waveform value at a 24-bit phase, straight from the definitions (default parameters).
    function automatic int wave(input int md, input bit [23:0] ph);
        int p;
        int q;
        int i;
        int mag;
        p = int'(ph >> 14);
        q = p / 256;
        i = p % 256;
        case (md)
            0: begin
                mag = (q % 2 == 0) ? lut[i] : lut[255 - i];
                return (q < 2) ? mag : -mag;
            end
            1:       return (p < 512) ? A : -A;
            2:       return p - 512;
            default: return (p < 512) ? 2 * p - A : 2 * (1023 - p) - A;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit e, input bit s, input bit l, input bit [23:0] f,
                        input bit [23:0] po, input bit [1:0] md, input int ly, input int lx);
        exp_t t;
        @(negedge clk);
        en   = e;
        sync = s;
        load = l;
        fcw  = f;
        poff = po;
        mode = md;
        if (e) begin
            t.y  = wave(int'(md), m_acc + po);
            t.x  = wave(int'(md), m_acc + po + 24'h400000);
            t.ly = ly;
            t.lx = lx;
            sb_q.push_back(t);
            pushed++;
        end
        if (s)      m_acc = 24'h0;
        else if (e) m_acc = m_acc + m_fcw;
        if (l)      m_fcw = f;
    endtask

    task automatic rand_steps(input int n);
        for (int j = 0; j < n; j++) begin
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
                 24'($urandom), 24'($urandom), 2'($urandom_range(0, 3)), NOLIT, NOLIT);
        end
    endtask

    task automatic monitor();
        exp_t t;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && valid_o === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_valid: valid_o=1 with no sample expected at %0t", $time);
                end else begin
                    t = sb_q.pop_front();
                    popped++;
                    chk("model_Y", int'(Y), t.y);
                    chk("model_X", int'(X), t.x);
                    if (t.ly != NOLIT) chk("directed_Y", int'(Y), t.ly);
                    if (t.lx != NOLIT) chk("directed_X", int'(X), t.lx);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin
            lut[k] = int'($floor(511.0 * $sin(3.14159265358979 * (real'(k) + 0.5) / 512.0) + 0.5));
        end
        rst_n = 1'b0;
        en    = 1'b0;
        sync  = 1'b0;
        load  = 1'b0;
        fcw   = '0;
        poff  = '0;
        mode  = '0;
        m_acc = '0;
        m_fcw = '0;
        #1;
        chk("reset_X", int'(X), 0);
        chk("reset_Y", int'(Y), 0);
        chk("reset_valid", int'(valid_o), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fork
            monitor();
        join_none

        // Sine quadrature at a quarter cycle per sample.
        step(0, 0, 1, 24'h400000, 0, 2'd0, NOLIT, NOLIT);
        step(0, 1, 0, 0, 0, 2'd0, NOLIT, NOLIT);
        for (int j = 0; j < 8; j++) step(1, 0, 0, 0, 0, 2'd0, ysin[j % 4], xsin[j % 4]);

        // Square, same step.
        step(0, 1, 0, 0, 0, 2'd1, NOLIT, NOLIT);
        for (int j = 0; j < 8; j++) step(1, 0, 0, 0, 0, 2'd1, ysq[j % 4], xsq[j % 4]);

        // Accumulator wrap with fcw = all ones, observed through the sawtooth.
        step(0, 1, 1, 24'hFFFFFF, 0, 2'd2, NOLIT, NOLIT);
        step(1, 0, 0, 0, 0, 2'd2, -512, -256);
        step(1, 0, 0, 0, 0, 2'd2, 511, -257);
        step(1, 0, 0, 0, 0, 2'd2, 511, -257);

        // sync + load + en together: acc clears, next increments use the new word.
        step(0, 1, 1, 24'h100000, 0, 2'd2, NOLIT, NOLIT);
        step(1, 1, 1, 24'h200000, 0, 2'd2, -512, -256);
        step(1, 0, 0, 24'h300000, 0, 2'd2, -512, -256);
        step(1, 0, 0, 24'h300000, 0, 2'd2, -384, -128);
        step(1, 0, 0, 24'h300000, 0, 2'd2, -256, 0);

        // Triangle then sawtooth sweeps, one output LSB per sample.
        step(0, 1, 1, 24'h004000, 0, 2'd3, NOLIT, NOLIT);
        for (int j = 0; j < 1025; j++) begin
            step(1, 0, 0, 0, 0, 2'd3,
                 (j == 0 || j == 1023 || j == 1024) ? -511 : ((j == 511 || j == 512) ? 511 : NOLIT), NOLIT);
        end
        step(0, 1, 0, 0, 0, 2'd2, NOLIT, NOLIT);
        for (int j = 0; j < 1025; j++) begin
            step(1, 0, 0, 0, 0, 2'd2,
                 (j == 0 || j == 1024) ? -512 : ((j == 1023) ? 511 : NOLIT), NOLIT);
        end
        repeat (5) step(0, 0, 0, 0, 0, 2'd0, NOLIT, NOLIT);

        rand_steps(600);

        // Asynchronous reset with samples in flight.
        step(0, 0, 1, 24'h123456, 0, 2'd0, NOLIT, NOLIT);
        repeat (6) step(1, 0, 0, 0, 24'h0ABCDE, 2'd0, NOLIT, NOLIT);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_X", int'(X), 0);
        chk("midrst_Y", int'(Y), 0);
        chk("midrst_valid", int'(valid_o), 0);
        pushed = pushed - sb_q.size();
        sb_q.delete();
        m_acc = '0;
        m_fcw = '0;
        en    = 1'b0;
        sync  = 1'b0;
        load  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) step(0, 0, 0, 0, 0, 2'd0, NOLIT, NOLIT);
        rand_steps(150);

        repeat (6) step(0, 0, 0, 0, 0, 2'd0, NOLIT, NOLIT);
        chk("scoreboard_empty", sb_q.size(), 0);
        chk("push_pop_count", popped, pushed);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
